pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//   Parametrised multi-lane pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
//   Replaces bare stall/flush stage registers (e.g. decode->execute) for the dual-issue pipeline.
//   Moves one issue group (NLANES lanes, each DATA_W bits) per cycle and absorbs downstream backpressure.
//   in_ready is registered, so there is no combinational ready path from the consumer to the producer.
// PARAMETERS
//   NLANES  2    lanes per issue group
//   DATA_W  128  payload bits per lane
//   CNT_W   32   width of each performance counter (used only with PIPE_STAGE_PERF_EN)
// PORTS
//   clk        in   1              clock
//   rst        in   1              reset; synchronous, active-high
//   flush      in   1              discard all held and incoming groups
//   in_valid   in   NLANES         per-lane valid of the incoming group
//   in_data    in   NLANES*DATA_W  incoming payload; lane i at [i*DATA_W +: DATA_W]
//   in_ready   out  1              stage accepts a group this cycle (registered)
//   out_valid  out  NLANES         per-lane valid of the head group
//   out_data   out  NLANES*DATA_W  head payload
//   out_ready  in   1              consumer takes the head group
// BEHAVIOUR
//   - Handshake events:
//     - in_fire  = in_ready & |in_valid; the group is accepted whole.
//     - out_fire = out_ready & |out_valid.
//     - A group with in_valid==0 is a bubble and is never stored.
//   - Capture: lanes whose in_valid bit is clear are stored with data zeroed. Lane order is preserved; no compaction.
//   - Storage: main (head) and skid entries. Occupancy FSM states are EMPTY, ONE and FULL.
//     - EMPTY: in_fire -> ONE, main<=in.
//     - ONE, in_fire & out_fire -> ONE, main<=in.
//     - ONE, in_fire & !out_fire -> FULL, skid<=in.
//     - ONE, !in_fire & out_fire -> EMPTY.
//     - ONE, otherwise -> hold.
//     - FULL: out_fire -> ONE, main<=skid. Otherwise hold.
//   - in_ready is registered and equals (next_state != FULL). It is 0 in FULL, and 1 in EMPTY and ONE.
//   - Latency and throughput: 1 cycle when EMPTY; 1 group/cycle sustained with out_ready=1.
//   - out_valid/out_data come straight from main. They read all-zero when EMPTY.
//   - out_valid and out_data hold stable while out_valid!=0 and out_ready=0.
//   - Flush has priority over everything in that cycle:
//     - next state EMPTY, main and skid valids and data cleared to 0, in_ready<=1;
//     - the concurrent input group is dropped; out_fire in that cycle is still counted as consumed.
//   - Reset gives the same result as flush: out_valid=0, out_data=0, in_ready=1, state EMPTY.
//     Reset mid-transfer drops both entries.
//   - No ordering reversal: skid always drains into main before any new group is accepted.
// CONFIGURATION
//   - PIPE_STAGE_PERF_EN defined:
//     - adds outputs perf_stall_cnt[CNT_W] (cycles with |out_valid & !out_ready);
//     - adds perf_full_cnt[CNT_W] (cycles in FULL);
//     - adds perf_flush_cnt[CNT_W] (flush cycles that discarded at least one valid lane);
//     - counters reset to 0 on rst (not on flush) and wrap modulo 2^CNT_W.
//   - PIPE_STAGE_PERF_EN undefined: the three ports and the counter logic are absent; all other behaviour is identical.
// STRUCTURE
//   - pipeline_pkg: typedef stage_state_e {ST_EMPTY, ST_ONE, ST_FULL};
//     constant PIPE_NOP_LANE = '0; lane slice helper function.
//   - Sub-module pipe_group_reg: one NLANES-wide entry (valid vector + data) with load, clear and zero-on-invalid.
//     Instantiated twice, as main and skid.
//   - The top holds the FSM, the registered ready, the flush priority and the optional counters.
// TESTING
//   1. Reset, then idle: out_valid=0, out_data=0, in_ready=1 on the first post-reset cycle.
//   2. Streaming: NLANES=2, out_ready=1, groups {2'b11,A,B} then {2'b01,C,X} on back-to-back cycles.
//      Expect the same groups one cycle later. Lane1 of the second group reads 0, not X. No gaps.
//   3. Backpressure: out_ready=0 while sending G0 and G1.
//      G0 is held at the output and G1 goes to skid; in_ready drops to 0 one cycle after G1 is accepted.
//      With out_ready=1, G0 then G1 drain on consecutive cycles and in_ready returns to 1.
//   4. Bubble: in_valid=2'b00 with in_data=all-ones. State and outputs are unchanged and nothing is stored.
//   5. Flush in FULL together with a new input: next cycle out_valid=0, in_ready=1. Neither the new nor the held groups ever appear.
//   6. PIPE_STAGE_PERF_EN: 5 cycles of stalled valid output plus 3 in FULL -> perf_stall_cnt=5, perf_full_cnt=3.
//      Also CNT_W=4 wrap check after 16 stall cycles -> 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and helpers for the pipeline stage registers.
//   stage_state_e  occupancy of a two-entry stage (empty, head only, head + skid)
//   PIPE_NOP_LANE  fill bit written into the payload of a lane that is not valid
//   lane_lo()      low bit index of a lane inside a flattened issue group
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } stage_state_e;

  localparam logic PIPE_NOP_LANE = '0;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_group_reg.sv
// pipe_group_reg: one issue-group entry (per-lane valid vector + payload).
// A load captures the group with every invalid lane's payload forced to zero.
// A clear (or rst) empties the entry; clear wins over load.
//   clk, rst    clock, synchronous active-high reset
//   clear       empty the entry this cycle
//   load        capture load_valid/load_data this cycle
//   load_valid  per-lane valid of the group to capture
//   load_data   payload of the group to capture, lane i at [i*DATA_W +: DATA_W]
//   valid       per-lane valid of the held group
//   data        payload of the held group
module pipe_group_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned NLANES = 2,
  parameter int unsigned DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NLANES-1:0]        load_valid,
  input  logic [NLANES*DATA_W-1:0] load_data,
  output logic [NLANES-1:0]        valid,
  output logic [NLANES*DATA_W-1:0] data
);

  logic [NLANES*DATA_W-1:0] masked;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    localparam int unsigned LO = lane_lo(g, DATA_W);
    assign masked[LO +: DATA_W] = load_valid[g] ? load_data[LO +: DATA_W]
                                                : {DATA_W{PIPE_NOP_LANE}};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= load_valid;
      data  <= masked;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: multi-lane pipeline stage register with valid/ready handshake
// and a two-entry (main + skid) buffer. in_ready is a flop, so there is no
// combinational path from out_ready to in_ready.
// Optional feature macro: PIPE_STAGE_PERF_EN adds three performance counters.
//   clk, rst        clock, synchronous active-high reset
//   flush           discard held and incoming groups
//   in_valid        per-lane valid of the incoming group (all-zero = bubble)
//   in_data         incoming payload, lane i at [i*DATA_W +: DATA_W]
//   in_ready        stage accepts a group this cycle
//   out_valid       per-lane valid of the head group
//   out_data        head payload (zero when empty)
//   out_ready       consumer takes the head group
//   perf_stall_cnt  cycles with a valid head not taken     (PIPE_STAGE_PERF_EN)
//   perf_full_cnt   cycles spent with both entries in use  (PIPE_STAGE_PERF_EN)
//   perf_flush_cnt  flushes that discarded a valid lane    (PIPE_STAGE_PERF_EN)
module pipe_stage_skid
  import pipeline_pkg::*;
#(
  parameter int unsigned NLANES = 2,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NLANES-1:0]        in_valid,
  input  logic [NLANES*DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic [NLANES-1:0]        out_valid,
  output logic [NLANES*DATA_W-1:0] out_data,
  input  logic                     out_ready
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]         perf_stall_cnt,
  output logic [CNT_W-1:0]         perf_full_cnt,
  output logic [CNT_W-1:0]         perf_flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid: CNT_W must be at least 1");
  end

  stage_state_e state, next_state;

  logic                     in_fire, out_fire;
  logic                     main_load, main_clear, main_from_skid;
  logic                     skid_load, skid_clear;
  logic [NLANES-1:0]        main_valid, skid_valid, main_src_valid;
  logic [NLANES*DATA_W-1:0] main_data, skid_data, main_src_data;

  assign in_fire   = in_ready && (|in_valid);
  assign out_fire  = out_ready && (|main_valid);
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign main_src_valid = main_from_skid ? skid_valid : in_valid;
  assign main_src_data  = main_from_skid ? skid_data  : in_data;

  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      next_state = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            next_state = ST_ONE;
            main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            next_state = ST_FULL;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            // Clear main so the outputs read zero while empty.
            next_state = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid can refill main.
          if (out_fire) begin
            next_state     = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != ST_FULL);
    end
  end

  pipe_group_reg #(
    .NLANES (NLANES),
    .DATA_W (DATA_W)
  ) u_main (
    .clk        (clk),
    .rst        (rst),
    .clear      (main_clear),
    .load       (main_load),
    .load_valid (main_src_valid),
    .load_data  (main_src_data),
    .valid      (main_valid),
    .data       (main_data)
  );

  pipe_group_reg #(
    .NLANES (NLANES),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (skid_clear),
    .load       (skid_load),
    .load_valid (in_valid),
    .load_data  (in_data),
    .valid      (skid_valid),
    .data       (skid_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic stalled, flush_drop;

  assign stalled = (|main_valid) && !out_ready;
  // A held head that is taken in the flush cycle counts as consumed, not dropped.
  assign flush_drop = flush && (stalled || (|skid_valid) || in_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stalled)           perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (state == ST_FULL)  perf_full_cnt  <= perf_full_cnt + 1'b1;
      if (flush_drop)        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
